// File: rtl/polyvec_addsub_sched_pkg.sv
// Shared control definitions for the polynomial-vector add/sub sequencer.
// Holds the FSM encoding, vector/bank limits and small bank helpers.
package polyvec_addsub_sched_pkg;

   localparam int MAX_POLYS      = 8;
   localparam int BANK_W         = 3;
   localparam int BLANK_CYCLES   = 8;
   localparam int TIMEOUT_CYCLES = 1024;
   // Modulus used by the engine in subtract mode (q - operand).
   localparam int DILITHIUM_Q    = 8380417;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_RUN   = 3'd2,
      ST_GAP   = 3'd3,
      ST_FIN   = 3'd4
   } sched_state_e;

   function automatic logic [BANK_W-1:0] bank_of(input logic [BANK_W-1:0] base,
                                                 input logic [3:0]        idx);
      return base + BANK_W'(idx);
   endfunction

   function automatic logic num_legal(input logic [3:0] num);
      return (num != 4'd0) && (num <= 4'(MAX_POLYS));
   endfunction

endpackage

// File: rtl/polyvec_addsub_sched_watchdog.sv
// Per-polynomial blanking and timeout counters for the add/sub sequencer.
// elapsed_r counts cycles since the start cycle, so the first RUN cycle reads 1.
module sched_watchdog #(
   parameter int BLANK   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic srst,
   input  logic load,
   input  logic run,
   input  logic write_done,
   output logic done_qualified,
   output logic timeout_hit
);

   localparam int BW = $clog2(BLANK + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [BW-1:0] blank_r;
   logic [TW-1:0] elapsed_r;

   // Blank down-counter and saturating elapsed-cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_r   <= BW'(0);
         elapsed_r <= TW'(0);
      end else if (srst) begin
         blank_r   <= BW'(0);
         elapsed_r <= TW'(0);
      end else if (load) begin
         blank_r   <= BW'(BLANK);
         elapsed_r <= TW'(1);
      end else if (run) begin
         if (blank_r != BW'(0)) begin
            blank_r <= blank_r - BW'(1);
         end else begin
            blank_r <= blank_r;
         end
         if (elapsed_r != TW'(TIMEOUT)) begin
            elapsed_r <= elapsed_r + TW'(1);
         end else begin
            elapsed_r <= elapsed_r;
         end
      end else begin
         blank_r   <= blank_r;
         elapsed_r <= elapsed_r;
      end
   end

   // Hit on the last RUN cycle so the error pulse lands TIMEOUT cycles after start
   always_comb begin
      done_qualified = run & write_done & (blank_r == BW'(0));
      timeout_hit    = run & (elapsed_r == TW'(TIMEOUT - 1));
   end

endmodule

// File: rtl/polyvec_addsub_sched.sv
// Sequencer that walks one vector command through the add/sub write engine,
// one polynomial at a time, owning the bank select and add/sub mode line.
module polyvec_addsub_sched
   import polyvec_addsub_sched_pkg::*;
#(
   parameter int BLANK   = BLANK_CYCLES,
   parameter int TIMEOUT = TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_num_polys,
   input  logic [BANK_W-1:0] cmd_base_bank,
   input  logic              cmd_sub,
   input  logic              abort,
   output logic              write_start,
   output logic              write_working,
   input  logic              write_done,
   output logic              add_sub_sel,
   output logic [BANK_W-1:0] bank_sel,
   output logic [3:0]        poly_idx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   sched_state_e      state_r, next_state_s;
   logic [3:0]        num_r, num_s, poly_idx_r, poly_idx_s;
   logic [BANK_W-1:0] base_r, base_s, bank_sel_r, bank_sel_s;
   logic              add_sub_sel_r, add_sub_sel_s;
   logic              cmd_ready_r, cmd_ready_s, busy_r, busy_s;
   logic              write_start_r, write_start_s, write_working_r, write_working_s;
   logic              done_r, done_s, err_r, err_s;
   logic              accept_s, legal_s, abort_s, last_s, load_s, run_s;
   logic              done_qualified_s, timeout_hit_s;

   assign accept_s = cmd_valid & cmd_ready_r;
   assign legal_s  = num_legal(cmd_num_polys);
   assign abort_s  = abort & (state_r != ST_IDLE);
   assign last_s   = (poly_idx_r == (num_r - 4'd1));
   assign load_s   = (state_r == ST_START);
   assign run_s    = (state_r == ST_RUN);

   sched_watchdog #(
      .BLANK   (BLANK),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk            (clk),
      .rst_n          (rst_n),
      .srst           (abort_s),
      .load           (load_s),
      .run            (run_s),
      .write_done     (write_done),
      .done_qualified (done_qualified_s),
      .timeout_hit    (timeout_hit_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; abort wins, and completion wins over a same-cycle timeout
   always_comb begin
      next_state_s = state_r;
      if (abort_s) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:  next_state_s = (accept_s && legal_s) ? ST_START : ST_IDLE;
            ST_START: next_state_s = ST_RUN;
            ST_RUN: begin
               if (done_qualified_s) begin
                  next_state_s = last_s ? ST_FIN : ST_GAP;
               end else if (timeout_hit_s) begin
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = ST_RUN;
               end
            end
            ST_GAP:   next_state_s = ST_START;
            ST_FIN:   next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
         endcase
      end
   end

   // Output and datapath next values, registered below so outputs align with state
   always_comb begin
      cmd_ready_s     = (next_state_s == ST_IDLE);
      busy_s          = (next_state_s != ST_IDLE);
      write_start_s   = (next_state_s == ST_START);
      write_working_s = (next_state_s == ST_START) || (next_state_s == ST_RUN);
      done_s          = (state_r == ST_FIN) && !abort_s;
      err_s           = abort_s
                        || ((state_r == ST_IDLE) && accept_s && !legal_s)
                        || (run_s && timeout_hit_s && !done_qualified_s);
      num_s           = num_r;
      base_s          = base_r;
      add_sub_sel_s   = add_sub_sel_r;
      poly_idx_s      = poly_idx_r;
      bank_sel_s      = bank_sel_r;
      if ((state_r == ST_IDLE) && accept_s && legal_s) begin
         num_s         = cmd_num_polys;
         base_s        = cmd_base_bank;
         add_sub_sel_s = cmd_sub;
         poly_idx_s    = 4'd0;
         bank_sel_s    = cmd_base_bank;
      end else if (run_s && !abort_s && done_qualified_s && !last_s) begin
         poly_idx_s = poly_idx_r + 4'd1;
      end else if ((state_r == ST_GAP) && !abort_s) begin
         bank_sel_s = bank_of(base_r, poly_idx_r);
      end else begin
         poly_idx_s = poly_idx_r;
      end
   end

   // Output and command registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready_r     <= 1'b1;
         busy_r          <= 1'b0;
         write_start_r   <= 1'b0;
         write_working_r <= 1'b0;
         done_r          <= 1'b0;
         err_r           <= 1'b0;
         num_r           <= 4'd0;
         base_r          <= {BANK_W{1'b0}};
         add_sub_sel_r   <= 1'b0;
         poly_idx_r      <= 4'd0;
         bank_sel_r      <= {BANK_W{1'b0}};
      end else begin
         cmd_ready_r     <= cmd_ready_s;
         busy_r          <= busy_s;
         write_start_r   <= write_start_s;
         write_working_r <= write_working_s;
         done_r          <= done_s;
         err_r           <= err_s;
         num_r           <= num_s;
         base_r          <= base_s;
         add_sub_sel_r   <= add_sub_sel_s;
         poly_idx_r      <= poly_idx_s;
         bank_sel_r      <= bank_sel_s;
      end
   end

   assign cmd_ready     = cmd_ready_r;
   assign busy          = busy_r;
   assign write_start   = write_start_r;
   assign write_working = write_working_r;
   assign done          = done_r;
   assign err           = err_r;
   assign add_sub_sel   = add_sub_sel_r;
   assign poly_idx      = poly_idx_r;
   assign bank_sel      = bank_sel_r;

endmodule

// File: tb/tb_polyvec_addsub_sched.sv
// Self-checking bench for polyvec_addsub_sched: per-scenario tasks against a
// timing model (start spacing D+2, done at N*(D+2)+1 after accept).
module tb_polyvec_addsub_sched;
   import polyvec_addsub_sched_pkg::*;

   localparam int BLANK_T   = 8;
   localparam int TIMEOUT_T = 1024;
   localparam int NBANKS    = 1 << BANK_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_num_polys;
   logic [BANK_W-1:0] cmd_base_bank;
   logic              cmd_sub;
   logic              abort;
   logic              write_start;
   logic              write_working;
   logic              write_done;
   logic              add_sub_sel;
   logic [BANK_W-1:0] bank_sel;
   logic [3:0]        poly_idx;
   logic              busy;
   logic              done;
   logic              err;

   always #5 clk = ~clk;

   polyvec_addsub_sched #(.BLANK(BLANK_T), .TIMEOUT(TIMEOUT_T)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_num_polys (cmd_num_polys),
      .cmd_base_bank (cmd_base_bank),
      .cmd_sub       (cmd_sub),
      .abort         (abort),
      .write_start   (write_start),
      .write_working (write_working),
      .write_done    (write_done),
      .add_sub_sel   (add_sub_sel),
      .bank_sel      (bank_sel),
      .poly_idx      (poly_idx),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   eng_mode = 2;   // 0: done D cycles after start, 1: stuck high, 2: silent
   int   eng_d    = 20;
   int   eng_start = -1;
   int   start_q[$];
   int   bank_q[$];
   int   idx_q[$];
   int   done_q[$];
   int   err_q[$];
   int   sel_bad = 0;
   logic exp_sub = 1'b0;

   task automatic clear_log();
      start_q.delete(); bank_q.delete(); idx_q.delete();
      done_q.delete(); err_q.delete(); sel_bad = 0;
   endtask

   // Advance one cycle, log events seen in the new cycle, then drive the engine model.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (write_start === 1'b1) begin
         start_q.push_back(cyc);
         bank_q.push_back(int'(bank_sel));
         idx_q.push_back(int'(poly_idx));
      end
      if (done === 1'b1) done_q.push_back(cyc);
      if (err === 1'b1) err_q.push_back(cyc);
      if (busy === 1'b1 && add_sub_sel !== exp_sub) sel_bad++;
      case (eng_mode)
         0:       write_done = (eng_start >= 0) && (cyc >= eng_start + eng_d);
         1:       write_done = 1'b1;
         default: write_done = 1'b0;
      endcase
      if (write_start === 1'b1) eng_start = cyc;
   endtask

   task automatic send_cmd(input int n, input int base, input logic sub, output int a);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL cmd_ready_before_accept: got %b want 1", cmd_ready);
      end
      cmd_valid     = 1'b1;
      cmd_num_polys = 4'(n);
      cmd_base_bank = BANK_W'(base);
      cmd_sub       = sub;
      a = cyc;
      if (n >= 1 && n <= MAX_POLYS) exp_sub = sub;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_event(input int budget, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         tick();
         if (done_q.size() > 0 || err_q.size() > 0) seen = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_num_polys = 4'd0; cmd_base_bank = '0;
      cmd_sub = 1'b0; abort = 1'b0; write_done = 1'b0;
      eng_mode = 2; eng_start = -1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      clear_log();
   endtask

   task automatic test_reset();
      logic [13:0] got;
      do_reset();
      got = {cmd_ready, write_start, write_working, add_sub_sel, bank_sel, poly_idx, busy, done, err};
      n_cmp++;
      if (got !== 14'h2000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want %h", got, 14'h2000);
      end
   endtask

   // Full command checked against the start-spacing / done-latency model.
   task automatic check_cmd(input string name, input int n, input int base, input int d,
                            input int a, input bit seen);
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL %s_wait: no done/err within budget", name); end
      n_cmp++;
      if (start_q.size() != n) begin
         n_bad++; $display("FAIL %s_starts: got %0d want %0d", name, start_q.size(), n);
      end
      for (int i = 0; i < n && i < start_q.size(); i++) begin
         n_cmp++;
         if (bank_q[i] != (base + i) % NBANKS || idx_q[i] != i || start_q[i] - a != 1 + i * (d + 2)) begin
            n_bad++;
            $display("FAIL %s_poly%0d: bank %0d idx %0d t %0d want bank %0d idx %0d t %0d", name, i,
                     bank_q[i], idx_q[i], start_q[i] - a, (base + i) % NBANKS, i, 1 + i * (d + 2));
         end
      end
      n_cmp++;
      if (done_q.size() != 1 || err_q.size() != 0 || done_q[0] - a != n * (d + 2) + 1) begin
         n_bad++;
         $display("FAIL %s_done: dones %0d errs %0d t %0d want 1 0 t %0d", name, done_q.size(),
                  err_q.size(), (done_q.size() > 0) ? done_q[0] - a : -1, n * (d + 2) + 1);
      end
      n_cmp++;
      if (sel_bad != 0) begin
         n_bad++; $display("FAIL %s_add_sub_sel: %0d busy cycles differ from %b", name, sel_bad, exp_sub);
      end
   endtask

   task automatic test_latency();
      int a; bit seen;
      clear_log(); eng_mode = 0; eng_d = 140; eng_start = -1;
      send_cmd(3, 2, 1'b0, a);
      wait_event(3 * 142 + 40, seen);
      repeat (4) tick();
      check_cmd("latency", 3, 2, 140, a, seen);
   endtask

   task automatic test_bank_wrap();
      int a; bit seen; int d;
      d = int'($urandom_range(30, 9));
      clear_log(); eng_mode = 0; eng_d = d;
      send_cmd(2, 7, 1'b1, a);
      wait_event(2 * (d + 2) + 40, seen);
      repeat (3) tick();
      check_cmd("wrap", 2, 7, d, a, seen);
   endtask

   task automatic test_stale_done();
      int a; bit seen; int s; int low_cnt;
      clear_log(); eng_mode = 1; write_done = 1'b1;
      send_cmd(1, 5, 1'b0, a);
      s = cyc;
      low_cnt = (write_working !== 1'b1) ? 1 : 0;
      for (int k = 1; k <= BLANK_T; k++) begin
         tick();
         if (write_working !== 1'b1) low_cnt++;
      end
      n_cmp++;
      if (low_cnt != 0 || done_q.size() != 0) begin
         n_bad++; $display("FAIL stale_blanking: working low %0d cycles, dones %0d, want 0 0", low_cnt, done_q.size());
      end
      wait_event(40, seen);
      repeat (4) tick();
      n_cmp++;
      if (!seen || done_q.size() != 1 || done_q[0] - s != BLANK_T + 3) begin
         n_bad++;
         $display("FAIL stale_done: dones %0d t %0d want 1 t %0d", done_q.size(),
                  (done_q.size() > 0) ? done_q[0] - s : -1, BLANK_T + 3);
      end
      eng_mode = 2; write_done = 1'b0;
      tick();
   endtask

   task automatic test_illegal();
      int ns[3]; int a; int ready_low;
      ns[0] = 0; ns[1] = 9; ns[2] = int'($urandom_range(15, 10));
      for (int j = 0; j < 3; j++) begin
         clear_log();
         send_cmd(ns[j], int'($urandom_range(NBANKS - 1, 0)), 1'($urandom), a);
         ready_low = (cmd_ready !== 1'b1) ? 1 : 0;
         repeat (3) begin
            tick();
            if (cmd_ready !== 1'b1) ready_low++;
         end
         n_cmp++;
         if (err_q.size() != 1 || err_q[0] != a + 1 || start_q.size() != 0 || ready_low != 0) begin
            n_bad++;
            $display("FAIL illegal_n%0d: errs %0d at %0d starts %0d ready_low %0d want 1 at %0d 0 0", ns[j],
                     err_q.size(), (err_q.size() > 0) ? err_q[0] - a : -1, start_q.size(), ready_low, 1);
         end
      end
   endtask

   task automatic test_timeout();
      int a; bit seen;
      clear_log(); eng_mode = 2; write_done = 1'b0;
      send_cmd(2, 1, 1'b0, a);
      wait_event(TIMEOUT_T + 50, seen);
      n_cmp++;
      if (!seen || err_q.size() != 1 || start_q.size() != 1 || done_q.size() != 0
          || err_q[0] - start_q[0] != TIMEOUT_T) begin
         n_bad++;
         $display("FAIL timeout_err: errs %0d starts %0d dones %0d t %0d want 1 1 0 t %0d", err_q.size(),
                  start_q.size(), done_q.size(),
                  (err_q.size() > 0 && start_q.size() > 0) ? err_q[0] - start_q[0] : -1, TIMEOUT_T);
      end
      n_cmp++;
      if (write_working !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_state: working %b busy %b ready %b want 0 0 1", write_working, busy, cmd_ready);
      end
      tick();
   endtask

   task automatic test_abort();
      int a; int c;
      clear_log(); eng_mode = 0; eng_d = 20;
      send_cmd(4, 3, 1'b1, a);
      for (int k = 0; k < 200 && start_q.size() < 2; k++) tick();
      n_cmp++;
      if (start_q.size() != 2) begin
         n_bad++; $display("FAIL abort_reach_poly1: starts %0d want 2", start_q.size());
      end
      repeat (5) tick();
      abort = 1'b1;
      c = cyc;
      tick();
      abort = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || write_working !== 1'b0) begin
         n_bad++; $display("FAIL abort_next_cycle: err %b busy %b working %b want 1 0 0", err, busy, write_working);
      end
      repeat (60) tick();
      n_cmp++;
      if (start_q.size() != 2 || done_q.size() != 0 || err_q.size() != 1 || err_q[0] != c + 1) begin
         n_bad++;
         $display("FAIL abort_after: starts %0d dones %0d errs %0d want 2 0 1", start_q.size(),
                  done_q.size(), err_q.size());
      end
      clear_log();
      abort = 1'b1;
      repeat (2) tick();
      abort = 1'b0;
      tick();
      n_cmp++;
      if (err_q.size() != 0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL abort_idle: errs %0d ready %b busy %b want 0 1 0", err_q.size(), cmd_ready, busy);
      end
   endtask

   task automatic test_reset_mid();
      int a; logic [13:0] got;
      clear_log(); eng_mode = 0; eng_d = 30;
      send_cmd(3, 4, 1'b1, a);
      repeat (10) tick();
      #2;
      rst_n = 1'b0;
      #1;
      got = {cmd_ready, write_start, write_working, add_sub_sel, bank_sel, poly_idx, busy, done, err};
      n_cmp++;
      if (got !== 14'h2000) begin
         n_bad++; $display("FAIL reset_mid_outputs: got %h want %h", got, 14'h2000);
      end
      clear_log(); eng_mode = 2; eng_start = -1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (40) tick();
      n_cmp++;
      if (start_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0 || cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_mid_after: starts %0d dones %0d errs %0d ready %b want 0 0 0 1",
                  start_q.size(), done_q.size(), err_q.size(), cmd_ready);
      end
   endtask

   // Random commands issued back to back in the cycle the previous done pulses.
   task automatic test_back_to_back();
      int a; bit seen; int n; int base; int d; logic sub;
      eng_mode = 0;
      for (int it = 0; it < 6; it++) begin
         n    = int'($urandom_range(MAX_POLYS, 1));
         base = int'($urandom_range(NBANKS - 1, 0));
         d    = int'($urandom_range(40, BLANK_T + 1));
         sub  = 1'($urandom);
         clear_log(); eng_d = d;
         send_cmd(n, base, sub, a);
         wait_event(n * (d + 2) + 40, seen);
         check_cmd("b2b", n, base, d, a, seen);
      end
      repeat (3) tick();
   endtask

   initial begin
      $display("add/sub sequencer bench, subtract mode uses q = %0d", DILITHIUM_Q);
      test_reset();
      test_latency();
      test_bank_wrap();
      test_stale_done();
      test_illegal();
      test_timeout();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

endmodule
